// File: rtl/cpu_div_pkg.sv
// cpu_div_pkg: shared types and constants for the iterative restoring divider
package cpu_div_pkg;
    localparam int DIV_W = 32;
    localparam int DIV_LATENCY = DIV_W + 2;
    localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = '1;
    localparam int CNT_W = $clog2(DIV_W) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/cpu_div_cell_if.sv
// cpu_div_cell_if: E-stage request / M-stage response bundle of the divider
// master: drives E_start, E_src1, E_src2, E_signed, E_rem_sel; reads M_div_*
// slave:  reads E_*; drives M_div_busy, M_div_done, M_div_result, M_div_by_zero
interface cpu_div_cell_if
    import cpu_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_W
);
    logic                  E_start;
    logic [DATA_WIDTH-1:0] E_src1;
    logic [DATA_WIDTH-1:0] E_src2;
    logic                  E_signed;
    logic                  E_rem_sel;
    logic                  M_div_busy;
    logic                  M_div_done;
    logic [DATA_WIDTH-1:0] M_div_result;
    logic                  M_div_by_zero;
    modport master (
        output E_start, E_src1, E_src2, E_signed, E_rem_sel,
        input  M_div_busy, M_div_done, M_div_result, M_div_by_zero
    );
    modport slave (
        input  E_start, E_src1, E_src2, E_signed, E_rem_sel,
        output M_div_busy, M_div_done, M_div_result, M_div_by_zero
    );
endinterface

// File: rtl/cpu_div_step.sv
// cpu_div_step: one combinational restoring iteration (shift in dividend MSB, trial subtract)
// in: rem, msb, divisor; out: rem_next, q_bit
module cpu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] shifted, diff;
    assign shifted  = {rem, msb};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/cpu_div_cell.sv
// cpu_div_cell: iterative radix-2 restoring divider, signed/unsigned, quotient or remainder
// clk, reset (sync active-high); bus: cpu_div_cell_if.slave (E_* request, M_div_* response)
// optional macro DIV_ZERO_FASTPATH_EN: divisor==0 finishes one cycle after acceptance
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_W
) (
    input logic           clk,
    input logic           reset,
    cpu_div_cell_if.slave bus
);
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rem, dvd, dvs, rem_next, q_fix, r_fix, a1, a2;
    logic                  q_bit, q_neg, r_neg, rem_sel, by_zero, accept;

    // dvd doubles as the quotient register: quotient bits shift in as dividend bits shift out
    cpu_div_step #(.W(DATA_WIDTH)) u_step (
        .rem(rem), .msb(dvd[DATA_WIDTH-1]), .divisor(dvs), .rem_next(rem_next), .q_bit(q_bit)
    );

    // a zero divisor leaves rem = |dividend|, so re-applying the dividend sign restores the original
    always_comb begin
        accept = bus.E_start && (state == IDLE || state == DONE);
        a1     = (bus.E_signed && bus.E_src1[DATA_WIDTH-1]) ? -bus.E_src1 : bus.E_src1;
        a2     = (bus.E_signed && bus.E_src2[DATA_WIDTH-1]) ? -bus.E_src2 : bus.E_src2;
        q_fix  = by_zero ? DATA_WIDTH'(DIV_ZERO_QUOT) : q_neg ? -dvd : dvd;
        r_fix  = r_neg ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            rem               <= '0;
            dvd               <= '0;
            dvs               <= '0;
            q_neg             <= 1'b0;
            r_neg             <= 1'b0;
            rem_sel           <= 1'b0;
            by_zero           <= 1'b0;
            bus.M_div_busy    <= 1'b0;
            bus.M_div_done    <= 1'b0;
            bus.M_div_result  <= '0;
            bus.M_div_by_zero <= 1'b0;
        end else begin
            bus.M_div_done <= 1'b0;
            if (accept) begin
                dvd            <= a1;
                dvs            <= a2;
                rem            <= '0;
                q_neg          <= bus.E_signed && (bus.E_src1[DATA_WIDTH-1] ^ bus.E_src2[DATA_WIDTH-1]);
                r_neg          <= bus.E_signed && bus.E_src1[DATA_WIDTH-1];
                rem_sel        <= bus.E_rem_sel;
                by_zero        <= bus.E_src2 == '0;
                cnt            <= CNT_W'(DATA_WIDTH - 1);
                state          <= CALC;
                bus.M_div_busy <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                if (bus.E_src2 == '0) begin
                    state             <= DONE;
                    bus.M_div_busy    <= 1'b0;
                    bus.M_div_done    <= 1'b1;
                    bus.M_div_result  <= bus.E_rem_sel ? bus.E_src1 : DATA_WIDTH'(DIV_ZERO_QUOT);
                    bus.M_div_by_zero <= 1'b1;
                end
`endif
            end else begin
                case (state)
                    CALC: begin
                        rem   <= rem_next;
                        dvd   <= {dvd[DATA_WIDTH-2:0], q_bit};
                        cnt   <= cnt - 1'b1;
                        state <= (cnt == '0) ? FIXUP : CALC;
                    end
                    FIXUP: begin
                        bus.M_div_result  <= rem_sel ? r_fix : q_fix;
                        bus.M_div_by_zero <= by_zero;
                        bus.M_div_busy    <= 1'b0;
                        bus.M_div_done    <= 1'b1;
                        state             <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_div_cell.sv
// tb_cpu_div_cell: randomized self-checking bench for cpu_div_cell against an arithmetic model
module tb_cpu_div_cell;
    localparam int LAT = 34;
`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;
    logic        last_bz = 1'b0;

    cpu_div_cell_if bus ();
    cpu_div_cell dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg, input logic rs);
        longint x, y, q, r;
        if (b == 0) return rs ? a : 32'hFFFF_FFFF;
        x = sg ? longint'($signed(a)) : longint'({32'b0, a});
        y = sg ? longint'($signed(b)) : longint'({32'b0, b});
        q = x / y;
        r = x % y;
        return rs ? r[31:0] : q[31:0];
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic rs);
        bus.E_src1 = a;
        bus.E_src2 = b;
        bus.E_signed = sg;
        bus.E_rem_sel = rs;
        bus.E_start = 1'b1;
        @(posedge clk); #1;
        bus.E_start = 1'b0;
    endtask

    // returns the cycle (acceptance edge = 0) at which done is seen; busy and held outputs tracked on the way
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic rs,
                          output int lat, output logic busy_ok, output logic held_ok);
        start_op(a, b, sg, rs);
        lat = 1;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        while (bus.M_div_done !== 1'b1 && lat < 100) begin
            if (bus.M_div_busy !== 1'b1) busy_ok = 1'b0;
            if (bus.M_div_result !== last_res || bus.M_div_by_zero !== last_bz) held_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.M_div_busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.M_div_busy); end
        if (bus.M_div_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.M_div_done); end
        if (bus.M_div_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.M_div_result); end
        if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_by_zero: got %b want 0", bus.M_div_by_zero); end
        reset = 1'b0;
        @(posedge clk); #1;
        last_res = '0;
        last_bz = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat;
        logic bok, hok;
        logic [31:0] want [2] = '{32'd14, 32'd2};
        for (int i = 0; i < 2; i++) begin
            run_op(32'd100, 32'd7, 1'b0, 1'(i), lat, bok, hok);
            checks += 5;
            if (lat != LAT) begin errors++; $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            if (bus.M_div_result !== want[i]) begin errors++; $display("FAIL unsigned_result[%0d]: got %h want %h", i, bus.M_div_result, want[i]); end
            if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL unsigned_by_zero[%0d]: got %b want 0", i, bus.M_div_by_zero); end
            if (!bok) begin errors++; $display("FAIL unsigned_busy[%0d]: got mismatch want busy=1 cycles 1-33", i); end
            if (!hok) begin errors++; $display("FAIL unsigned_hold[%0d]: got change want held %h", i, last_res); end
            last_res = want[i];
            last_bz = 1'b0;
        end
    endtask

    task automatic test_signed;
        int lat;
        logic bok, hok;
        logic [31:0] src1 [4] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] src2 [4] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want [4] = '{32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_op(src1[i], src2[i], 1'b1, 1'(i % 2), lat, bok, hok);
            checks += 3;
            if (lat != LAT) begin errors++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            if (bus.M_div_result !== want[i]) begin errors++; $display("FAIL signed_result[%0d]: got %h want %h", i, bus.M_div_result, want[i]); end
            if (!hok) begin errors++; $display("FAIL signed_hold[%0d]: got change want held %h", i, last_res); end
            last_res = want[i];
            last_bz = 1'b0;
        end
    endtask

    task automatic test_div_zero;
        int lat;
        logic bok, hok;
        logic [31:0] src1 [3] = '{32'h1234_5678, 32'h1234_5678, 32'h8765_4321};
        logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8765_4321};
        for (int i = 0; i < 3; i++) begin
            run_op(src1[i], 32'h0, 1'(i == 2), 1'(i != 0), lat, bok, hok);
            checks += 4;
            if (lat != ZLAT) begin errors++; $display("FAIL zero_latency[%0d]: got %0d want %0d", i, lat, ZLAT); end
            if (bus.M_div_result !== want[i]) begin errors++; $display("FAIL zero_result[%0d]: got %h want %h", i, bus.M_div_result, want[i]); end
            if (bus.M_div_by_zero !== 1'b1) begin errors++; $display("FAIL zero_flag[%0d]: got %b want 1", i, bus.M_div_by_zero); end
            if (!bok) begin errors++; $display("FAIL zero_busy[%0d]: got mismatch want busy only while calculating", i); end
            last_res = want[i];
            last_bz = 1'b1;
        end
    endtask

    task automatic test_ignored_start;
        int ndone = 0;
        int dcyc = 0;
        logic [31:0] dres = '0;
        start_op(32'd1000, 32'd10, 1'b0, 1'b0);
        for (int c = 1; c <= 80; c++) begin
            bus.E_start = (c == 5 || c == 20);
            bus.E_src1 = 32'd49;
            bus.E_src2 = 32'd7;
            if (bus.M_div_done === 1'b1) begin ndone++; dcyc = c; dres = bus.M_div_result; end
            @(posedge clk); #1;
        end
        bus.E_start = 1'b0;
        checks += 4;
        if (ndone != 1) begin errors++; $display("FAIL ignored_done_count: got %0d want 1", ndone); end
        if (dcyc != LAT) begin errors++; $display("FAIL ignored_done_cycle: got %0d want %0d", dcyc, LAT); end
        if (dres !== 32'd100) begin errors++; $display("FAIL ignored_result: got %h want %h", dres, 32'd100); end
        if (bus.M_div_result !== 32'd100) begin errors++; $display("FAIL ignored_hold: got %h want %h", bus.M_div_result, 32'd100); end
        last_res = 32'd100;
        last_bz = 1'b0;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic bok, hok;
        run_op(32'd77, 32'd7, 1'b0, 1'b0, lat, bok, hok);
        last_res = 32'd11;
        last_bz = 1'b0;
        run_op(32'd50, 32'd5, 1'b0, 1'b0, lat, bok, hok);
        checks += 4;
        if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
        if (bus.M_div_result !== 32'd10) begin errors++; $display("FAIL b2b_result: got %h want %h", bus.M_div_result, 32'd10); end
        if (!hok) begin errors++; $display("FAIL b2b_hold: got change want held %h", last_res); end
        if (!bok) begin errors++; $display("FAIL b2b_busy: got mismatch want busy=1 cycles 1-33"); end
        last_res = 32'd10;
    endtask

    task automatic test_reset_mid;
        int lat;
        int ndone = 0;
        logic bok, hok;
        start_op(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks += 4;
        if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.M_div_busy); end
        if (bus.M_div_result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h want 0", bus.M_div_result); end
        if (bus.M_div_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", bus.M_div_done); end
        for (int c = 0; c < 40; c++) begin
            if (bus.M_div_done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        if (ndone != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
        last_res = '0;
        last_bz = 1'b0;
        run_op(32'd1000, 32'd3, 1'b0, 1'b0, lat, bok, hok);
        checks += 2;
        if (lat != LAT) begin errors++; $display("FAIL midreset_restart_latency: got %0d want %0d", lat, LAT); end
        if (bus.M_div_result !== 32'd333) begin errors++; $display("FAIL midreset_restart_result: got %h want %h", bus.M_div_result, 32'd333); end
        last_res = 32'd333;
    endtask

    task automatic test_random;
        int lat;
        logic bok, hok, sg, rs;
        logic [31:0] a, b, want;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: b = a;
                default: b = $urandom;
            endcase
            sg = 1'($urandom);
            rs = 1'($urandom);
            want = ref_div(a, b, sg, rs);
            run_op(a, b, sg, rs, lat, bok, hok);
            checks += 5;
            if (bus.M_div_result !== want) begin errors++; $display("FAIL rand_result[%0d] %h/%h s=%b r=%b: got %h want %h", i, a, b, sg, rs, bus.M_div_result, want); end
            if (bus.M_div_by_zero !== (b == 0)) begin errors++; $display("FAIL rand_by_zero[%0d]: got %b want %b", i, bus.M_div_by_zero, b == 0); end
            if (lat != ((b == 0) ? ZLAT : LAT)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, (b == 0) ? ZLAT : LAT); end
            if (!bok) begin errors++; $display("FAIL rand_busy[%0d]: got mismatch want busy only while calculating", i); end
            if (!hok) begin errors++; $display("FAIL rand_hold[%0d]: got change want held %h", i, last_res); end
            last_res = want;
            last_bz = (b == 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        bus.E_start = 1'b0;
        bus.E_src1 = '0;
        bus.E_src2 = '0;
        bus.E_signed = 1'b0;
        bus.E_rem_sel = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
